ascon_permutation_ctrl: RTL
===========================

Name: ascon_permutation_ctrl

Overview:
- Iterative Ascon-p[rnd] engine controller. It accepts a 320-bit state, applies 12 or 8 rounds at one round per clock, and returns the permuted state over a valid/ready handshake.
- It sequences the round index and round configuration into the round datapath (constant addition, substitution, linear diffusion).
- It sits between the mode FSMs (AEAD/hash/XOF) and the permutation datapath.

Parameters:
- NUM_ROUNDS_MAX, 12, rounds applied when round_config_i=1. Rounds when round_config_i=0 are NUM_ROUNDS_MAX-4 = 8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear_i  in  1  synchronous abort; returns to IDLE
- in_valid_i  in  1  input state valid
- in_ready_o  out  1  controller can accept a state
- round_config_i  in  1  1 = Ascon-p[12], 0 = Ascon-p[8]; sampled on accept only
- state_i  in  ascon_state_t  input state S0..S4
- out_valid_o  out  1  permuted state valid
- out_ready_i  in  1  consumer accepts output
- state_o  out  ascon_state_t  permuted state; valid when out_valid_o=1
- busy_o  out  1  high in RUN
- rnd_o  out  rnd_t  current round index, 0-based, for debug/bench visibility

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM=IDLE; state register, round counter and config register all cleared to 0.
  - in_ready_o=1, out_valid_o=0, busy_o=0, rnd_o=0, state_o=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: latch state_i and round_config_i, clear counter to 0, go to RUN.
  - No round is applied on the accept edge.
- RUN:
  - Each clock, state_reg <= round(state_reg, rnd_o, cfg_reg) and the counter increments.
  - Constant index into AsconRcLut is rnd_o when cfg=1 and rnd_o+4 when cfg=0. First constant is 0xf0 for 12 rounds and 0xb4 for 8 rounds; last constant is 0x4b in both cases.
  - When the counter equals last (11 for cfg=1, 7 for cfg=0), the final round is applied on that edge and the FSM goes to DONE. The counter holds at last.
  - in_valid_i is ignored in RUN (in_ready_o=0).
- DONE:
  - out_valid_o=1 and state_o=state_reg.
  - state_o and out_valid_o are held stable while out_ready_i=0 (unbounded backpressure).
  - On out_valid_o & out_ready_i: go to IDLE and clear the counter. The state register keeps its value until the next accept.
- Latency: accept at edge E0 gives out_valid_o high after edge E12 (cfg=1) or E8 (cfg=0). That is 13 or 9 cycles from the accept cycle to first valid output cycle.
- Throughput: one bubble. in_ready_o rises only in the cycle after the output handshake; there is no accept in DONE.
- clear_i:
  - Highest priority among synchronous events. Next state is IDLE, the counter is cleared, out_valid_o falls next cycle, and no output handshake is reported.
  - A simultaneous in_valid_i is not accepted.
- rst_n deasserted mid-RUN: everything returns to reset values immediately; the partial state is discarded.
- round_config_i and state_i changing during RUN/DONE have no effect.
- rnd_t width must hold 0..15; the counter never exceeds NUM_ROUNDS_MAX-1.

Decomposition:
- ascon_pkg: ascon_state_t, rnd_t, AsconRcLut (12 entries 0xf0..0x4b), and an FSM enum type (ctrl_state_t: IDLE, RUN, DONE).
- Sub-module ascon_round is purely combinational: constant_addition_layer, then substitution layer, then linear diffusion layer, with inputs rnd_i, round_config_i and state_array_i.
- The controller instantiates ascon_round once. The controller holds all registers.

Test Plan:
- Reset/idle: assert rst_n=0 then release → in_ready_o=1, out_valid_o=0, busy_o=0, rnd_o=0, state_o=0.
- 12-round all-zero: state_i=0, round_config_i=1, pulse in_valid_i, out_ready_i=1 → rnd_o steps 0..11 over 12 cycles; out_valid_o high exactly 13 cycles after accept; state_o equals the bench behavioural Ascon-p[12] of 0. After the handshake in_ready_o=1 next cycle.
- 8-round random: random state, round_config_i=0 → dut.ascon_round constant equals 0xb4 in the first RUN cycle and 0x4b in the last; out_valid_o after 9 cycles; state_o equals model Ascon-p[8]. Repeat 20 random vectors for both configs.
- Backpressure and ignore: hold out_ready_i=0 for 5 cycles in DONE while in_valid_i=1 with a new state → state_o stable, in_ready_o=0, no second accept. Release out_ready_i → IDLE, then the new state is accepted.
- clear_i at rnd_o=5 → next cycle IDLE, in_ready_o=1, out_valid_o never asserts. A following job produces the correct model result.
- Async reset at rnd_o=3 (rst_n low mid-cycle) → outputs reach reset values before the next clock edge. Recovery job is correct.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types, round-constant table and helpers for the Ascon permutation engine.
package ascon_pkg;

    localparam int NUM_ROUNDS_MAX = 12;

    // Five 64-bit words, S0 at index 0.
    typedef logic [4:0][63:0] ascon_state_t;
    typedef logic [3:0]       rnd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    localparam logic [0:11][7:0] AsconRcLut = {
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // Reduced-round variants use the tail of the table so both end on 0x4b.
    function automatic logic [7:0] ascon_rc(input rnd_t rnd, input logic cfg);
        rnd_t idx;
        idx = cfg ? rnd : rnd + 4'd4;
        return (idx < 4'd12) ? AsconRcLut[idx] : 8'h00;
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
// Purely combinational.
module ascon_round
    import ascon_pkg::*;
(
    input  rnd_t         rnd_i,
    input  logic         round_config_i,
    input  ascon_state_t state_array_i,
    output ascon_state_t state_array_o
);

    logic [7:0]  rc;
    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] s0, s1, s2, s3, s4;

    assign rc = ascon_rc(rnd_i, round_config_i);

    assign c0 = state_array_i[0];
    assign c1 = state_array_i[1];
    assign c2 = state_array_i[2] ^ {56'd0, rc};
    assign c3 = state_array_i[3];
    assign c4 = state_array_i[4];

    // Bitsliced S-box
    assign a0 = c0 ^ c4;
    assign a1 = c1;
    assign a2 = c2 ^ c1;
    assign a3 = c3;
    assign a4 = c4 ^ c3;

    assign t0 = ~a0 & a1;
    assign t1 = ~a1 & a2;
    assign t2 = ~a2 & a3;
    assign t3 = ~a3 & a4;
    assign t4 = ~a4 & a0;

    assign b0 = a0 ^ t1;
    assign b1 = a1 ^ t2;
    assign b2 = a2 ^ t3;
    assign b3 = a3 ^ t4;
    assign b4 = a4 ^ t0;

    assign s1 = b1 ^ b0;
    assign s0 = b0 ^ b4;
    assign s3 = b3 ^ b2;
    assign s2 = ~b2;
    assign s4 = b4;

    assign state_array_o[0] = s0 ^ rotr64(s0, 19) ^ rotr64(s0, 28);
    assign state_array_o[1] = s1 ^ rotr64(s1, 61) ^ rotr64(s1, 39);
    assign state_array_o[2] = s2 ^ rotr64(s2, 1)  ^ rotr64(s2, 6);
    assign state_array_o[3] = s3 ^ rotr64(s3, 10) ^ rotr64(s3, 17);
    assign state_array_o[4] = s4 ^ rotr64(s4, 7)  ^ rotr64(s4, 41);

endmodule

// File: rtl/ascon_permutation_ctrl.sv
// Iterative Ascon-p[12]/p[8] controller: one round per clock, result held
// in DONE until the consumer takes it (unbounded backpressure, no accept in DONE).
module ascon_permutation_ctrl
    import ascon_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         round_config_i,
    input  ascon_state_t state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         busy_o,
    output rnd_t         rnd_o
);

    ctrl_state_t  fsm_q;
    ascon_state_t st_q;
    ascon_state_t st_d;
    rnd_t         rnd_q;
    rnd_t         rnd_last_d;
    logic         cfg_q;
    logic         in_rdy_q;
    logic         out_vld_q;
    logic         busy_q;

    ascon_round u_round (
        .rnd_i          (rnd_q),
        .round_config_i (cfg_q),
        .state_array_i  (st_q),
        .state_array_o  (st_d)
    );

    assign rnd_last_d = cfg_q ? rnd_t'(NUM_ROUNDS_MAX - 1) : rnd_t'(NUM_ROUNDS_MAX - 5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            st_q      <= '0;
            rnd_q     <= '0;
            cfg_q     <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (clear_i) begin
            fsm_q     <= IDLE;
            rnd_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        st_q     <= state_i;
                        cfg_q    <= round_config_i;
                        rnd_q    <= '0;
                        fsm_q    <= RUN;
                        in_rdy_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    st_q <= st_d;
                    if (rnd_q == rnd_last_d) begin
                        fsm_q     <= DONE;
                        busy_q    <= 1'b0;
                        out_vld_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    // State register is kept; it is only overwritten by the next accept.
                    if (out_ready_i) begin
                        fsm_q     <= IDLE;
                        rnd_q     <= '0;
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q     <= IDLE;
                    rnd_q     <= '0;
                    in_rdy_q  <= 1'b1;
                    out_vld_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_rdy_q;
    assign out_valid_o = out_vld_q;
    assign busy_o      = busy_q;
    assign rnd_o       = rnd_q;
    assign state_o     = st_q;

endmodule
